// File: rtl/shift_sched_pkg.sv
// rtl/shift_sched_pkg.sv - shared state and compare-code encodings for the shift job scheduler
package shift_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;
  localparam logic [1:0] CMP_EQ = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter; pointer moves to the loser on handshake
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    if (req == 2'b11) begin
      grant_id = ptr;
    end else begin
      grant_id = req[1];
    end
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/shift_job_scheduler.sv
// rtl/shift_job_scheduler.sv - shares one shift datapath between two requesters and checks its result
module shift_job_scheduler
  import shift_sched_pkg::*;
#(
  parameter int W          = 4,
  parameter int DP_LATENCY = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_c,
  output logic [1:0]       rsp_cmp,
  output logic             rsp_err,
  output logic             dp_start,
  output logic [W-1:0]     dp_a,
  output logic [W-1:0]     dp_b,
  input  logic [W-1:0]     dp_c,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt0,
  output logic [CNT_W-1:0] op_cnt1
);

  localparam int CW = $clog2(DP_LATENCY + 1);

  sched_state_t  state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic          id_q;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    grant;
  logic          grant_id;
  logic          idle;
  logic          accept;
  logic          wait_done;
  logic          rsp_fire;
  logic [W-1:0]  exp_c;
  logic [1:0]    cmp_c;

  // Requests are masked outside IDLE (and while reset is held) so nothing is granted mid-job.
  assign idle = (state == ST_IDLE) && !reset;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (reset),
    .req      (req_valid & {2{idle}}),
    .update   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign wait_done = (state == ST_WAIT) && (wait_cnt == CW'(1));
  assign rsp_fire  = (state == ST_RESP) && rsp_ready;

  assign dp_start  = (state == ST_ISSUE);
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;

  always_comb begin
    cmp_c = CMP_EQ;
    exp_c = a_q;
    if (a_q < b_q) begin
      cmp_c = CMP_LT;
      exp_c = a_q << 1;
    end else if (a_q > b_q) begin
      cmp_c = CMP_GT;
      exp_c = b_q >> 1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_ISSUE;
      ST_ISSUE:                state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_done) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_fire)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      wait_cnt <= '0;
      rsp_c    <= '0;
      rsp_cmp  <= '0;
      rsp_err  <= 1'b0;
      op_cnt0  <= '0;
      op_cnt1  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= grant_id ? req_a1 : req_a0;
        b_q  <= grant_id ? req_b1 : req_b0;
        id_q <= grant_id;
      end
      if (state == ST_ISSUE) begin
        wait_cnt <= CW'(DP_LATENCY);
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      // Result and its classification are frozen here and held through RESP.
      if (wait_done) begin
        rsp_c   <= dp_c;
        rsp_cmp <= cmp_c;
        rsp_err <= (dp_c != exp_c);
      end
      if (rsp_fire) begin
        if (id_q) op_cnt1 <= op_cnt1 + CNT_W'(1);
        else      op_cnt0 <= op_cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_job_scheduler.sv
// tb/tb_shift_job_scheduler.sv - scoreboard bench for shift_job_scheduler with a behavioural datapath
module tb_shift_job_scheduler;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] op_a [2];
  logic [3:0] op_b [2];
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0] rsp_c;
  logic [1:0] rsp_cmp;
  logic       dp_start;
  logic [3:0] dp_a, dp_b;
  logic [3:0] dp_c = 4'h0;
  logic       busy;
  logic [7:0] op_cnt0, op_cnt1;
  logic       force_bad;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  shift_job_scheduler #(.W(W), .DP_LATENCY(1), .CNT_W(8)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(op_a[0]), .req_b0(op_b[0]), .req_a1(op_a[1]), .req_b1(op_b[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .busy(busy), .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
  );

  function automatic logic [3:0] ref_c(input logic [3:0] a, input logic [3:0] b);
    int ai = int'(a);
    int bi = int'(b);
    if (ai < bi) return 4'((ai * 2) % 16);
    if (ai > bi) return 4'(bi / 2);
    return a;
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [3:0] a, input logic [3:0] b);
    if (int'(a) < int'(b)) return 2'b01;
    if (int'(a) > int'(b)) return 2'b10;
    return 2'b11;
  endfunction

  // Datapath stand-in: one clock from the start edge to a valid C.
  always @(posedge clk) begin
    if (dp_start) dp_c <= force_bad ? 4'hF : ref_c(dp_a, dp_b);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int id);
    logic [3:0] c_true;
    logic [3:0] c_seen;
    c_true = ref_c(op_a[id], op_b[id]);
    c_seen = force_bad ? 4'hF : c_true;
    exp_q.push_back({1'(id), c_seen, ref_cmp(op_a[id], op_b[id]), (c_seen != c_true)});
  endtask

  function automatic logic [1:0] arb(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Monitor: keeps a transaction-level model of the scheduler and pops the scoreboard.
  int         cycle;
  int         acc_cycle;
  logic       model_busy;
  logic       model_ptr;
  logic [7:0] m_cnt0, m_cnt1;
  logic [3:0] acc_a, acc_b;
  logic       prev_stall;
  logic [7:0] prev_rsp;

  initial begin
    logic [1:0] exp_ready;
    logic [7:0] e;
    logic       eid;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_busy = 1'b0; model_ptr = 1'b0; m_cnt0 = 8'd0; m_cnt1 = 8'd0;
        acc_cycle = -100; cycle = 0; prev_stall = 1'b0; acc_a = 4'd0; acc_b = 4'd0;
      end else begin
        cycle++;
        chk("busy", busy, model_busy);
        exp_ready = model_busy ? 2'b00 : arb(req_valid, model_ptr);
        chk("req_ready", req_ready, exp_ready);
        chk("dp_start", dp_start, cycle == acc_cycle + 1);
        if (dp_start) chk("dp_operands", {dp_a, dp_b}, {acc_a, acc_b});
        chk("rsp_valid", rsp_valid, model_busy && (cycle - acc_cycle >= 3));
        if (prev_stall) chk("rsp_hold", {rsp_id, rsp_c, rsp_cmp, rsp_err}, prev_rsp);
        chk("op_cnt0", op_cnt0, m_cnt0);
        chk("op_cnt1", op_cnt1, m_cnt1);
        if (rsp_valid && rsp_ready) begin
          eid = rsp_id;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            eid = e[7];
            chk("rsp_fields", {rsp_id, rsp_c, rsp_cmp, rsp_err}, e);
          end
          model_busy = 1'b0;
          if (eid) m_cnt1 = m_cnt1 + 8'd1;
          else     m_cnt0 = m_cnt0 + 8'd1;
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = {rsp_id, rsp_c, rsp_cmp, rsp_err};
        if (|(req_ready & req_valid)) begin
          model_busy = 1'b1;
          model_ptr  = ~req_ready[1];
          acc_cycle  = cycle;
          acc_a      = op_a[req_ready[1]];
          acc_b      = op_b[req_ready[1]];
        end
      end
    end
  end

  task automatic job(input int id, input logic [3:0] a, input logic [3:0] b);
    logic got = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_valid[id] = 1'b1;
    op_a[id] = a;
    op_b[id] = b;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin push(id); got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin done = 1'b1; break; end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_cmp, rsp_err, dp_start, busy}, 0);
    chk("reset_dat", {dp_a, dp_b, op_cnt0, op_cnt1}, 0);
    rst = 1'b0;
  endtask

  task automatic run_mode(input int n, input bit both, input bit rand_ready, input int max_acc);
    logic held [2];
    int   acc = 0;
    held[0] = 1'b0; held[1] = 1'b0;
    for (int c = 0; c < n && acc < max_acc; c++) begin
      @(posedge clk); #1;
      rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (!held[i]) begin
          req_valid[i] = both ? 1'b1 : ($urandom_range(0, 2) == 0);
          op_a[i] = 4'($urandom);
          op_b[i] = 4'($urandom);
        end else if (!both && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin push(i); acc++; end
        held[i] = req_valid[i] && !req_ready[i];
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
  endtask

  initial begin
    logic got;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1; force_bad = 1'b0;
    op_a[0] = 4'd0; op_b[0] = 4'd0; op_a[1] = 4'd0; op_b[1] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_cmp, rsp_err, dp_start, busy}, 0);
    chk("reset_dat", {dp_a, dp_b, op_cnt0, op_cnt1}, 0);
    rst = 1'b0;

    job(0, 4'b0010, 4'b0101);
    drain();
    job(1, 4'b0101, 4'b0010);
    job(1, 4'b1001, 4'b1100);
    drain();

    apply_reset();
    run_mode(40, 1'b1, 1'b0, 4);
    drain();
    chk("both_cnt0", op_cnt0, 2);
    chk("both_cnt1", op_cnt1, 2);
    job(0, 4'b0101, 4'b0101);
    drain();

    // Response back-pressure with both requesters waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    job(0, 4'b0011, 4'b0011);
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    op_a[0] = 4'd6; op_b[0] = 4'd1; op_a[1] = 4'd2; op_b[1] = 4'd9;
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin push(req_ready[1] ? 1 : 0); got = 1'b1; break; end
    end
    if (!got) chk("stall_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Asynchronous reset in the middle of a job.
    job(0, 4'b0100, 4'b0111);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midjob_reset_ctl", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_cmp, rsp_err, dp_start, busy}, 0);
    chk("midjob_reset_dat", {dp_a, dp_b, op_cnt0, op_cnt1}, 0);
    exp_q.delete();
    req_valid = 2'b11;
    op_a[0] = 4'd1; op_b[0] = 4'd8; op_a[1] = 4'd8; op_b[1] = 4'd1;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("rr_restart", req_ready, 2'b01);
    if (req_ready[0]) push(0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    job(1, 4'b1010, 4'b0110);
    drain();

    force_bad = 1'b1;
    job(0, 4'b0010, 4'b0101);
    drain();
    force_bad = 1'b0;

    run_mode(400, 1'b0, 1'b1, 1000);
    drain();

    apply_reset();
    for (int j = 0; j < 255; j++) job(0, 4'($urandom), 4'($urandom));
    drain();
    chk("cnt0_max", op_cnt0, 255);
    job(0, 4'd7, 4'd3);
    drain();
    chk("cnt0_wrap", op_cnt0, 0);
    chk("cnt1_idle", op_cnt1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
